// File: rtl/quad_encoder_emulator.sv
// quad_encoder_emulator: turns a signed RPM command into quadrature A/B edges
// at the RPM reader's scaling. A 32-step restoring divider converts |rpm| into
// a quarter-period in clock cycles; a run/stop FSM steps the phase at quarter
// boundaries. Optional index output: define ENC_EMU_INDEX_EN to add enc_z.
module quad_encoder_emulator #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned CLK_FREQ      = 27_000_000,
  parameter int unsigned PULSE_PER_REV = 27_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid_i,
  input  logic [DATA_WIDTH-1:0] cmd_rpm_i,
  output logic                  cmd_ready_o,
  output logic                  enc_a,
  output logic                  enc_b,
`ifdef ENC_EMU_INDEX_EN
  output logic                  enc_z,
`endif
  output logic                  running_o,
  output logic [31:0]           position_o
);

  // Clock cycles per A period at 1 RPM.
  localparam longint unsigned NumFull = 64'(60) * 64'(CLK_FREQ) / 64'(PULSE_PER_REV);
  localparam logic [31:0] NUMERATOR = NumFull[31:0];
  // Divisor |rpm|*4 peaks at 2^(DATA_WIDTH+1), so it needs DATA_WIDTH+2 bits.
  localparam int unsigned RemW = DATA_WIDTH + 2;

  typedef enum logic [0:0] {StStop, StRun} state_e;

  // Divider state
  logic            busy_q;
  logic [5:0]      div_cnt_q;
  logic [31:0]     dvd_q;      // dividend shifts out, quotient shifts in
  logic [RemW-1:0] rem_q;
  logic [RemW-1:0] dsr_q;
  logic            div_zero_q;
  logic            div_dir_q;

  // Pending command
  logic        pend_valid_q, pend_stop_q, pend_dir_q;
  logic [31:0] pend_quarter_q;

  // Sequencer state
  state_e      state_q;
  logic [31:0] quarter_q, qcnt_q;
  logic        dir_q;
  logic [1:0]  phase_q;
  logic        enc_a_q, enc_b_q, running_q;
  logic [31:0] position_q;

  // Command magnitude; the extra bit keeps -2^(DATA_WIDTH-1) representable.
  logic                cmd_sign;
  logic [DATA_WIDTH:0] cmd_ext, cmd_mag;
  logic                accept;

  assign cmd_sign = cmd_rpm_i[DATA_WIDTH-1];
  assign cmd_ext  = {cmd_sign, cmd_rpm_i};
  assign cmd_mag  = cmd_sign ? (~cmd_ext + 1'b1) : cmd_ext;
  assign accept   = cmd_valid_i & ~busy_q;

  // One restoring-division step; remainder stays below the divisor.
  logic [RemW:0]   rem_sh;
  logic [RemW-1:0] rem_sub;
  logic            rem_fits;
  logic            div_done;
  logic [31:0]     div_quarter;

  assign rem_sh      = {rem_q, dvd_q[31]};
  assign rem_fits    = rem_sh >= {1'b0, dsr_q};
  assign rem_sub     = rem_sh[RemW-1:0] - dsr_q;
  assign div_done    = busy_q && (div_cnt_q == 6'd32);
  assign div_quarter = (dvd_q == 32'd0) ? 32'd1 : dvd_q;

  // Divider: capture on accept, 32 iterations, then one cycle to publish.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q     <= 1'b0;
      div_cnt_q  <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
      div_zero_q <= 1'b0;
      div_dir_q  <= 1'b1;
    end else if (accept) begin
      busy_q     <= 1'b1;
      div_cnt_q  <= '0;
      dvd_q      <= NUMERATOR;
      rem_q      <= '0;
      dsr_q      <= {cmd_mag[DATA_WIDTH-1:0], 2'b00};
      div_zero_q <= (cmd_mag == '0);
      div_dir_q  <= ~cmd_sign;
    end else if (busy_q) begin
      if (div_done) begin
        busy_q <= 1'b0;
      end else begin
        dvd_q     <= {dvd_q[30:0], rem_fits};
        rem_q     <= rem_fits ? rem_sub : rem_sh[RemW-1:0];
        div_cnt_q <= div_cnt_q + 6'd1;
      end
    end
  end

  // A just-finished division is visible in the same cycle so STOP->RUN lands on N+33.
  logic        pend_avail, pend_stop, pend_dir;
  logic [31:0] pend_quarter;
  logic        boundary, consume;
  logic [1:0]  phase_nx;

  assign pend_avail   = div_done | pend_valid_q;
  assign pend_stop    = div_done ? div_zero_q  : pend_stop_q;
  assign pend_dir     = div_done ? div_dir_q   : pend_dir_q;
  assign pend_quarter = div_done ? div_quarter : pend_quarter_q;
  assign boundary     = (qcnt_q == quarter_q - 32'd1);
  assign consume      = pend_avail & ((state_q == StStop) | boundary);
  assign phase_nx     = dir_q ? (phase_q + 2'd1) : (phase_q - 2'd1);

  // Pending slot: newest completed command wins until the sequencer takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_valid_q   <= 1'b0;
      pend_stop_q    <= 1'b0;
      pend_dir_q     <= 1'b1;
      pend_quarter_q <= 32'd1;
    end else if (div_done && !consume) begin
      pend_valid_q   <= 1'b1;
      pend_stop_q    <= div_zero_q;
      pend_dir_q     <= div_dir_q;
      pend_quarter_q <= div_quarter;
    end else if (consume) begin
      pend_valid_q <= 1'b0;
    end
  end

`ifdef ENC_EMU_INDEX_EN
  localparam int unsigned IdxW = $clog2(4 * PULSE_PER_REV);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(4 * PULSE_PER_REV - 1);
  logic [IdxW-1:0] idx_q, idx_nx;
  logic            enc_z_q;

  assign idx_nx = dir_q ? ((idx_q == IdxLast) ? '0 : idx_q + 1'b1)
                        : ((idx_q == '0) ? IdxLast : idx_q - 1'b1);
  assign enc_z  = enc_z_q;

  // Index counter follows every phase step, wrapping at both ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q   <= '0;
      enc_z_q <= 1'b1;
    end else if (state_q == StRun && boundary && !(pend_avail && pend_stop)) begin
      idx_q   <= idx_nx;
      enc_z_q <= (idx_nx == '0);
    end
  end
`endif

  // Run/stop sequencer; speed/direction changes only at quarter boundaries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StStop;
      running_q  <= 1'b0;
      quarter_q  <= 32'd1;
      qcnt_q     <= '0;
      dir_q      <= 1'b1;
      phase_q    <= 2'd0;
      enc_a_q    <= 1'b0;
      enc_b_q    <= 1'b0;
      position_q <= '0;
    end else begin
      unique case (state_q)
        StStop: begin
          if (pend_avail && !pend_stop) begin
            quarter_q <= pend_quarter;
            dir_q     <= pend_dir;
            qcnt_q    <= '0;
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (boundary) begin
            qcnt_q <= '0;
            if (pend_avail && pend_stop) begin
              state_q   <= StStop;
              running_q <= 1'b0;
            end else begin
              phase_q    <= phase_nx;
              enc_a_q    <= phase_nx[1] ^ phase_nx[0];
              enc_b_q    <= phase_nx[1];
              position_q <= dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
              if (pend_avail) begin
                quarter_q <= pend_quarter;
                dir_q     <= pend_dir;
              end
            end
          end else begin
            qcnt_q <= qcnt_q + 32'd1;
          end
        end
        default: state_q <= StStop;
      endcase
    end
  end

  assign cmd_ready_o = ~busy_q;
  assign enc_a       = enc_a_q;
  assign enc_b       = enc_b_q;
  assign running_o   = running_q;
  assign position_o  = position_q;

endmodule
